// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the two-port AES core arbiter.
// State encoding, block width and requester count.
package aes_pkg;

    localparam int AES_W = 128;
    localparam int N_REQ = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/aes_arbiter_if.sv
// aes_arbiter_if: requester handshakes and AES core hookup.
// slave = arbiter side, master = requesters plus core side.
interface aes_arbiter_if
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_W
);
    logic              i_Req0;
    logic              i_Req1;
    logic              i_Dec0;
    logic              i_Dec1;
    logic [DATA_W-1:0] i_Text0;
    logic [DATA_W-1:0] i_Text1;
    logic [DATA_W-1:0] i_Key0;
    logic [DATA_W-1:0] i_Key1;
    logic              o_Ack0;
    logic              o_Ack1;
    logic              o_Vld0;
    logic              o_Vld1;
    logic              i_Rdy0;
    logic              i_Rdy1;
    logic [DATA_W-1:0] o_Data;
    logic              o_Err;
    logic              o_Busy;
    logic              o_fStart;
    logic              o_fDec;
    logic [DATA_W-1:0] o_Text;
    logic [DATA_W-1:0] o_Key;
    logic [DATA_W-1:0] i_Data;
    logic              i_fDone;

    modport slave (
        input  i_Req0, i_Req1, i_Dec0, i_Dec1,
        input  i_Text0, i_Text1, i_Key0, i_Key1,
        input  i_Rdy0, i_Rdy1, i_Data, i_fDone,
        output o_Ack0, o_Ack1, o_Vld0, o_Vld1,
        output o_Data, o_Err, o_Busy,
        output o_fStart, o_fDec, o_Text, o_Key
    );

    modport master (
        output i_Req0, i_Req1, i_Dec0, i_Dec1,
        output i_Text0, i_Text1, i_Key0, i_Key1,
        output i_Rdy0, i_Rdy1, i_Data, i_fDone,
        input  o_Ack0, o_Ack1, o_Vld0, o_Vld1,
        input  o_Data, o_Err, o_Busy,
        input  o_fStart, o_fDec, o_Text, o_Key
    );

endinterface

// File: rtl/aes_rr_grant.sv
// aes_rr_grant: 2-way round-robin pick.
// A lone request always wins; on a tie the pointer's port wins.
module aes_rr_grant
    import aes_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             ptr_nxt
);

    // one-hot grant, pointer moves to the other port after a grant
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            ptr_nxt = 1'b1;
        end else if (gnt[1]) begin
            ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// aes_arbiter: shares one AES-128 core between two requesters.
// Optional WAIT watchdog is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_arbiter
    import aes_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 31
) (
    input logic          i_Clk,
    input logic          i_Rst,
    aes_arbiter_if.slave bus
);

    if (DATA_W != AES_W) begin : g_bad_width
        $error("aes_arbiter: DATA_W must be 128");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("aes_arbiter: TIMEOUT must be at least 2");
    end

    state_t            state;
    state_t            state_nxt;
    logic              ptr;
    logic              ptr_nxt;
    logic              owner;
    logic              dec_q;
    logic [DATA_W-1:0] text_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] res_q;
    logic              err_q;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic              grant_en;
    logic              tmo;

    assign req      = {bus.i_Req1, bus.i_Req0};
    assign grant_en = (state == IDLE) && i_Rst;

    aes_rr_grant u_grant (
        .req     (req),
        .ptr     (ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // count WAIT cycles; zero whenever outside WAIT
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            cnt <= '0;
        end else if (state != WAIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt    = state;
        bus.o_Ack0   = gnt[0];
        bus.o_Ack1   = gnt[1];
        bus.o_Vld0   = 1'b0;
        bus.o_Vld1   = 1'b0;
        bus.o_Err    = 1'b0;
        bus.o_Busy   = (state != IDLE);
        bus.o_fStart = 1'b0;
        unique case (state)
            IDLE: begin
                if (|gnt) state_nxt = START;
            end
            START: begin
                bus.o_fStart = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (bus.i_fDone || tmo) state_nxt = RESP;
            end
            RESP: begin
                bus.o_Vld0 = !owner;
                bus.o_Vld1 = owner;
                bus.o_Err  = err_q;
                if (owner ? bus.i_Rdy1 : bus.i_Rdy0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // capture request on grant, result on done or timeout
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            ptr    <= 1'b0;
            owner  <= 1'b0;
            dec_q  <= 1'b0;
            text_q <= '0;
            key_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            if (state == IDLE && |gnt) begin
                owner  <= gnt[1];
                dec_q  <= gnt[1] ? bus.i_Dec1  : bus.i_Dec0;
                text_q <= gnt[1] ? bus.i_Text1 : bus.i_Text0;
                key_q  <= gnt[1] ? bus.i_Key1  : bus.i_Key0;
            end
            if (state == WAIT) begin
                if (bus.i_fDone) begin
                    res_q <= bus.i_Data;
                    err_q <= 1'b0;
                end else if (tmo) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_Data = res_q;
    assign bus.o_Text = text_q;
    assign bus.o_Key  = key_q;
    assign bus.o_fDec = dec_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: scoreboard bench for aes_arbiter with a core stub.
// Stub answers the FIPS-197 AES-128 vector pair after a fixed latency.
module tb_aes_arbiter;
    import aes_pkg::*;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int LAT = 6;

    typedef struct {
        int           port;
        logic [127:0] data;
        bit           err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    aes_arbiter_if #(.DATA_W(AES_W)) bus ();

    aes_arbiter #(.DATA_W(AES_W), .TIMEOUT(31)) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t res_q[$];
    int   gnt_q[$];

    bit   no_done = 1'b0;
    bit   stray   = 1'b0;
    int   s_cnt;
    bit   ack_prev;
    bit   done_prev;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic dec,
                                             input logic [127:0] t,
                                             input logic [127:0] k);
        if (k == KEY && !dec && t == PT) return CT;
        if (k == KEY && dec && t == CT) return PT;
        return t ^ k;
    endfunction

    // core stub: done LAT cycles after start, from the live core inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt       <= 0;
            bus.i_fDone <= 1'b0;
            bus.i_Data  <= '1;
        end else begin
            bus.i_fDone <= stray;
            bus.i_Data  <= '1;
            if (bus.o_fStart) begin
                s_cnt <= LAT;
            end else if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1 && !no_done) begin
                    bus.i_fDone <= 1'b1;
                    bus.i_Data  <= aes_ref(bus.o_fDec, bus.o_Text, bus.o_Key);
                end
            end
        end
    end

    task automatic serve(input int p, input bit dec, input logic [127:0] text,
                         input logic [127:0] key, input logic [127:0] exp_d,
                         input bit exp_e);
        bit got = 1'b0;
        @(negedge clk);
        if (p == 0) begin
            bus.i_Dec0 = dec; bus.i_Text0 = text; bus.i_Key0 = key;
            bus.i_Req0 = 1'b1;
        end else begin
            bus.i_Dec1 = dec; bus.i_Text1 = text; bus.i_Key1 = key;
            bus.i_Req1 = 1'b1;
        end
        for (int i = 0; i < 2000 && !got; i++) begin
            #1;
            got = (p == 0) ? bus.o_Ack0 : bus.o_Ack1;
            if (!got) @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack%0d: got no ack expected ack within budget", p);
        end else begin
            res_q.push_back('{p, exp_d, exp_e});
        end
        @(posedge clk);
        #1;
        if (p == 0) begin
            bus.i_Req0 = 1'b0; bus.i_Text0 = ~text; bus.i_Key0 = ~key;
        end else begin
            bus.i_Req1 = 1'b0; bus.i_Text1 = ~text; bus.i_Key1 = ~key;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (res_q.size() != 0 || gnt_q.size() != 0); i++)
            @(negedge clk);
        if (res_q.size() != 0 || gnt_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results %0d grants pending expected 0",
                     res_q.size(), gnt_q.size());
        end
    endtask

    // monitor: grants, start timing and results against the queues
    initial begin
        int   g;
        exp_t e;
        ack_prev  = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                ack_prev  = 1'b0;
                done_prev = 1'b0;
                continue;
            end
            if (bus.o_Ack0 || bus.o_Ack1) begin
                check("ack_onehot", bus.o_Ack0 & bus.o_Ack1, 0);
                check("ack_idle", bus.o_Busy, 0);
                if (gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got ack expected none");
                end else begin
                    g = gnt_q.pop_front();
                    check("ack_port", bus.o_Ack1, 128'(g));
                end
            end
            if (bus.o_fStart || ack_prev)
                check("start_after_ack", bus.o_fStart, ack_prev);
            if (done_prev)
                check("vld_after_done", bus.o_Vld0 | bus.o_Vld1, 1);
            ack_prev  = bus.o_Ack0 | bus.o_Ack1;
            done_prev = bus.i_fDone && bus.o_Busy && !bus.o_fStart &&
                        !bus.o_Vld0 && !bus.o_Vld1;
            if (bus.o_Vld0 || bus.o_Vld1) begin
                check("vld_onehot", bus.o_Vld0 & bus.o_Vld1, 0);
                check("vld_no_ack", bus.o_Ack0 | bus.o_Ack1, 0);
                check("vld_no_start", bus.o_fStart, 0);
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vld_unexpected: got valid expected none");
                end else begin
                    e = res_q[0];
                    check("vld_port", bus.o_Vld1, 128'(e.port));
                    check("data", bus.o_Data, e.data);
                    check("err", bus.o_Err, 128'(e.err));
                    if ((bus.o_Vld0 && bus.i_Rdy0) || (bus.o_Vld1 && bus.i_Rdy1))
                        void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        bus.i_Req0 = 0; bus.i_Req1 = 0; bus.i_Dec0 = 0; bus.i_Dec1 = 0;
        bus.i_Text0 = '0; bus.i_Text1 = '0; bus.i_Key0 = '0; bus.i_Key1 = '0;
        bus.i_Rdy0 = 1; bus.i_Rdy1 = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.o_Busy, 0);
        check("rst_vld0", bus.o_Vld0, 0);
        check("rst_vld1", bus.o_Vld1, 0);
        check("rst_start", bus.o_fStart, 0);
        check("rst_data", bus.o_Data, 0);
        check("rst_text", bus.o_Text, 0);
        @(negedge clk);
        rst_n = 1;

        // single encrypt on port 0
        gnt_q.push_back(0);
        serve(0, 1'b0, PT, KEY, CT, 1'b0);
        drain();

        // decrypt on port 1
        gnt_q.push_back(1);
        serve(1, 1'b1, CT, KEY, PT, 1'b0);
        drain();

        // stray done while idle is ignored
        @(negedge clk);
        stray = 1;
        @(negedge clk);
        stray = 0;
        repeat (3) @(negedge clk);
        #1;
        check("stray_busy", bus.o_Busy, 0);
        check("stray_vld", bus.o_Vld0 | bus.o_Vld1, 0);

        // simultaneous requests from reset alternate 0,1,0,1...
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            gnt_q.push_back(0);
            gnt_q.push_back(1);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) serve(0, 1'b0, PT, KEY, CT, 1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) serve(1, 1'b1, CT, KEY, PT, 1'b0);
            end
        join
        drain();

        // backpressure on port 0 with port 1 pending
        bus.i_Rdy0 = 0;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        serve(0, 1'b0, PT, KEY, CT, 1'b0);
        fork
            serve(1, 1'b1, CT, KEY, PT, 1'b0);
        join_none
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.o_Vld0;
        end
        check("bp_vld0_seen", seen, 1);
        repeat (20) @(negedge clk);
        check("bp_no_regrant", 128'(gnt_q.size()), 1);
        bus.i_Rdy0 = 1;
        @(negedge clk);
        #1;
        check("bp_idle_busy", bus.o_Busy, 0);
        check("bp_idle_vld0", bus.o_Vld0, 0);
        drain();

        // reset in WAIT
        gnt_q.push_back(0);
        serve(0, 1'b0, PT, KEY, CT, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mid_busy", bus.o_Busy, 1);
        rst_n = 0;
        #1;
        res_q.delete();
        check("mr_ack", bus.o_Ack0 | bus.o_Ack1, 0);
        check("mr_vld", bus.o_Vld0 | bus.o_Vld1, 0);
        check("mr_busy", bus.o_Busy, 0);
        check("mr_start", bus.o_fStart, 0);
        check("mr_err", bus.o_Err, 0);
        check("mr_dec", bus.o_fDec, 0);
        check("mr_text", bus.o_Text, 0);
        check("mr_key", bus.o_Key, 0);
        check("mr_data", bus.o_Data, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("post_rst_busy", bus.o_Busy, 0);
        gnt_q.push_back(1);
        serve(1, 1'b1, CT, KEY, PT, 1'b0);
        drain();

`ifdef AES_ARB_TIMEOUT_EN
        // core never answers: error result after 31 WAIT cycles
        no_done = 1;
        gnt_q.push_back(0);
        serve(0, 1'b0, PT, KEY, 128'h0, 1'b1);
        n = 0;
        seen = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.o_Vld0;
            n = i;
        end
        check("timeout_cycles", 128'(n), 33);
        drain();
        no_done = 0;
`else
        n = 0;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
